muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file: consumes its op_a/op_b read operands, and its write-back outputs (wb_en, wb_rd, wb_data) drive the register file's en/rd/data write port.
- Single-issue, multi-cycle: start/busy/done handshake; shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to execute all multiplies as a single-cycle 33x33 signed product.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  busy,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data
);
  localparam int CNT_W = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                  state_r, state_nx_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [2:0]              funct3_r;
  logic [REG_ADDR_W-1:0]   rd_r;
  logic                    neg_r;
  logic [XLEN-1:0]         opnd_r, hi_r, lo_r;
  logic                    busy_r, wb_en_r;
  logic [REG_ADDR_W-1:0]   wb_rd_r;
  logic [XLEN-1:0]         wb_data_r;

  logic                    accept_s, is_div_s, sign_a_s, sign_b_s;
  logic                    div_zero_s, div_ovf_s, fast_s, short_s;
  logic [XLEN-1:0]         mag_a_s, mag_b_s, short_res_s, fast_res_s;
  logic [XLEN:0]           mul_sum_s, rem_sh_s;
  logic [XLEN-1:0]         hi_nx_s, lo_nx_s;

  // hi/lo hold {product} for multiplies and {remainder, quotient} for divides.
  function automatic logic [XLEN-1:0] format_result(input logic [2:0] f3, input logic neg,
                                                    input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   qr;
    logic [XLEN-1:0]   res;
    prod = neg ? -{hi, lo} : {hi, lo};
    qr   = f3[1] ? hi : lo;
    if (f3[2]) begin
      res = neg ? -qr : qr;
    end else if (f3[1:0] == 2'b00) begin
      res = prod[XLEN-1:0];
    end else begin
      res = prod[2*XLEN-1:XLEN];
    end
    return res;
  endfunction

  assign accept_s   = start && (state_r != CALC);
  assign is_div_s   = funct3[2];
  assign sign_a_s   = op_a[XLEN-1] && !(funct3 inside {3'b011, 3'b101, 3'b111});
  assign sign_b_s   = op_b[XLEN-1] && (funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
  assign mag_a_s    = sign_a_s ? -op_a : op_a;
  assign mag_b_s    = sign_b_s ? -op_b : op_b;
  assign div_zero_s = is_div_s && (op_b == {XLEN{1'b0}});
  assign div_ovf_s  = is_div_s && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (op_b == {XLEN{1'b1}});
  assign short_s    = div_zero_s || div_ovf_s || fast_s;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod_s;
  assign fast_prod_s = $signed({sign_a_s && op_a[XLEN-1], op_a}) * $signed({sign_b_s && op_b[XLEN-1], op_b});
  assign fast_s      = !is_div_s;
  assign fast_res_s  = (funct3[1:0] == 2'b00) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
`else
  assign fast_s      = 1'b0;
  assign fast_res_s  = {XLEN{1'b0}};
`endif

  // Result for ops that skip the iterative path.
  always_comb begin
    short_res_s = {XLEN{1'b0}};
    if (div_zero_s) begin
      short_res_s = funct3[1] ? op_a : {XLEN{1'b1}};
    end else if (div_ovf_s) begin
      short_res_s = funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      short_res_s = fast_res_s;
    end
  end

  // One shift-add or restoring-subtract step.
  always_comb begin
    mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    rem_sh_s  = {hi_r, lo_r[XLEN-1]};
    hi_nx_s   = hi_r;
    lo_nx_s   = lo_r;
    if (funct3_r[2]) begin
      if (rem_sh_s >= {1'b0, opnd_r}) begin
        hi_nx_s = rem_sh_s[XLEN-1:0] - opnd_r;
        lo_nx_s = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        hi_nx_s = rem_sh_s[XLEN-1:0];
        lo_nx_s = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx_s = mul_sum_s[XLEN:1];
      lo_nx_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) state_nx_s = short_s ? DONE : CALC;
        else          state_nx_s = IDLE;
      end
      CALC: begin
        if (cnt_r == {CNT_W{1'b0}}) state_nx_s = DONE;
        else                        state_nx_s = CALC;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      wb_en_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == CALC);
      wb_en_r <= (state_nx_s == DONE);
    end
  end

  // Operand capture, iteration datapath and write-back registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      funct3_r  <= 3'd0;
      rd_r      <= {REG_ADDR_W{1'b0}};
      neg_r     <= 1'b0;
      opnd_r    <= {XLEN{1'b0}};
      hi_r      <= {XLEN{1'b0}};
      lo_r      <= {XLEN{1'b0}};
      wb_rd_r   <= {REG_ADDR_W{1'b0}};
      wb_data_r <= {XLEN{1'b0}};
    end else if (accept_s) begin
      cnt_r    <= CNT_W'(XLEN - 1);
      funct3_r <= funct3;
      rd_r     <= rd_in;
      neg_r    <= (is_div_s && funct3[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
      opnd_r   <= is_div_s ? mag_b_s : mag_a_s;
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= is_div_s ? mag_a_s : mag_b_s;
      if (short_s) begin
        wb_rd_r   <= rd_in;
        wb_data_r <= short_res_s;
      end else begin
        wb_rd_r   <= wb_rd_r;
        wb_data_r <= wb_data_r;
      end
    end else if (state_r == CALC) begin
      hi_r <= hi_nx_s;
      lo_r <= lo_nx_s;
      if (cnt_r == {CNT_W{1'b0}}) begin
        wb_rd_r   <= rd_r;
        wb_data_r <= format_result(funct3_r, neg_r, hi_nx_s, lo_nx_s);
      end else begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign busy    = busy_r;
  assign wb_en   = wb_en_r;
  assign wb_rd   = wb_rd_r;
  assign wb_data = wb_data_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected write-backs, a monitor pops on wb_en.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, wb_data;
  logic [4:0]  rd_in, wb_rd;
  logic        busy, wb_en;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
  localparam int MB = 0;
`else
  localparam int ML = 33;
  localparam int MB = 32;
`endif

  typedef struct {logic [4:0] rd; logic [31:0] data; int cyc;} exp_t;
  typedef struct {logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [4:0] rd;
                  logic [31:0] res; int lat; int nb;} vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[$];
  int   cyc = 0, checks = 0, errors = 0, nbusy = 0;

  muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .busy(busy), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy === 1'b1) nbusy <= nbusy + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write-back pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && wb_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got pulse rd %0d data %h expected no pulse", wb_rd, wb_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_data", wb_data, mon_e.data);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
        chk("latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat);
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1; nbusy = 0;
    sb.push_back('{rd, res, cyc + lat});
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom); funct3 = 3'($urandom);
  endtask

  task automatic drain(input int exp_busy);
    int i = 0;
    while (sb.size() != 0 && i < 80) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout: got %0d pending results after %0d cycles expected 0", sb.size(), i);
      sb.delete();
    end
    @(negedge clk);
    chk("busy_cycles", 32'(nbusy), 32'(exp_busy));
  endtask

  task automatic quiet(input int n);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wb_en === 1'b1) pulses++;
    end
    chk("no_pulse", 32'(pulses), 32'd0);
  endtask

  initial begin
    int w;
    rst = 1'b0; start = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    vecs.push_back('{3'b000, 32'd7,        32'd6,        5'd3,  32'd42,       ML, MB});
    vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, ML, MB});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, ML, MB});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, ML, MB});
    vecs.push_back('{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000001, ML, MB});
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33, 32});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33, 32});
    vecs.push_back('{3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       33, 32});
    vecs.push_back('{3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        33, 32});
    vecs.push_back('{3'b110, 32'd7,        32'hFFFFFFFE, 5'd9,  32'd1,        33, 32});
    vecs.push_back('{3'b100, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1,  0});
    vecs.push_back('{3'b111, 32'd5,        32'd0,        5'd11, 32'd5,        1,  0});
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1,  0});
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1,  0});

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_wb_en", {31'd0, wb_en}, 32'd0);
    chk("reset_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, vecs[i].lat);
      drain(vecs[i].nb);
    end

    // start and operand changes mid-calculation are ignored
    issue(3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 33);
    repeat (4) @(negedge clk);
    funct3 = 3'b101; op_a = 32'd9; op_b = 32'd3; rd_in = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = 32'd55;
    drain(32);
    repeat (3) @(negedge clk);
    chk("hold_data", wb_data, 32'd14);
    chk("hold_rd", {27'd0, wb_rd}, 32'd7);
    chk("hold_en", {31'd0, wb_en}, 32'd0);
    quiet(40);

    // back-to-back accept during the DONE cycle
    issue(3'b000, 32'd3, 32'd5, 5'd1, 32'd15, ML);
    w = 0;
    while (wb_en !== 1'b1 && w < 80) begin
      @(negedge clk);
      w++;
    end
    chk("b2b_wait", 32'(w < 80), 32'd1);
    funct3 = 3'b101; op_a = 32'd9; op_b = 32'd3; rd_in = 5'd2; start = 1'b1; nbusy = 0;
    sb.push_back('{5'd2, 32'd3, cyc + 33});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    drain(32);

    // asynchronous reset in the middle of a calculation
    issue(3'b101, 32'd1000, 32'd10, 5'd4, 32'd100, 33);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    chk("arst_wb_rd", {27'd0, wb_rd}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    quiet(40);
    issue(3'b000, 32'd3, 32'd4, 5'd5, 32'd12, ML);
    drain(MB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
